mem_cycle_responder: RTL and testbench
======================================

// Module: mem_cycle_responder
// PURPOSE
// Memory-side responder to the major-state sequencer (F0..F3, D0..D3, E0..E3, H0..H3 codes from parameters.v).
// Each 4-phase major cycle triggers one cycle here: address the core RAM, read, optionally modify, optionally write back.
// Also latches MB (memory buffer), applies auto-index increment for 0010-0017 during defer, and serves panel EXAM/DEP in H.
// Drives rdy high once MB is valid, which lets the sequencer and datapath advance out of X3.
// PARAMETERS
// AW        12  RAM address width (words = 2**AW; field bits are out of scope)
// RD_LAT    1   RAM read latency in clocks (1 or 2 supported)
// PORTS
// clk        in   1   system clock
// reset      in   1   synchronous, active-high reset
// state      in   5   major state from sequencer (parameters.v encoding)
// instruction in  12  current IR, bits [0:11], bit 0 = MSB
// pc         in   12  program counter [0:11]
// exec_wr    in   1   datapath requests E-cycle write (DCA/ISZ/JMS), sampled in E2
// exec_wdata in   12  data for E-cycle write, sampled in E2
// sr         in   12  panel switch register
// panel_dep  in   1   panel deposit request, sampled in H0 with trigger
// trigger    in   1   panel trigger (same signal the sequencer sees)
// ram_addr   out  AW  RAM address
// ram_rd     out  1   RAM read strobe
// ram_we     out  1   RAM write strobe
// ram_wdata  out  12  RAM write data
// ram_rdata  in   12  RAM read data, valid RD_LAT clocks after ram_rd
// mb         out  12  memory buffer (last word read/written)
// ea         out  12  effective address of current cycle
// autoidx    out  1   high from D2 to D3 when defer hit 0010-0017
// rdy        out  1   MB valid for this cycle
// BEHAVIOUR
// Reset: ram_addr=0, ram_rd=0, ram_we=0, ram_wdata=0, mb=0, ea=0, autoidx=0, rdy=0; any pending write is dropped.
// Internal FSM: IDLE -> ADDR -> WAIT(RD_LAT-1 clocks) -> CAP -> WB -> IDLE; driven by state; X0 resets FSM to IDLE.
// X0 (F0/D0/E0/H0): rdy<=0, ram_rd=0, ram_we=0; the X0 dwell length (sequencer wait count) is irrelevant here.
// X1: ea computed and driven on ram_addr; ram_rd=1 for exactly one clock:
//   F: ea=pc.  D: ea={instruction[4]?pc[0:4]:5'b0, instruction[5:11]}.
//   E: ea=instruction[3]?mb (pointer from D):{instruction[4]?pc[0:4]:0, instruction[5:11]}.
//   H: ea=sr (panel address).
// X2 (RD_LAT=1): mb<=ram_rdata. For RD_LAT=2, capture happens in X3 and write-back is deferred one clock (WB state).
// D capture: if ea[0:8]==9'o001 (0010-0017): mb<=(ram_rdata+1) mod 4096, autoidx<=1, write pending.
// E2: if exec_wr, then mb<=exec_wdata and write pending (overrides read data; ISZ increments in datapath).
// H: panel_dep latched at H0 when trigger; H2 then mb<=sr, write pending; otherwise EXAM (read only).
// X3: write pending -> ram_we=1 one clock, ram_addr=ea, ram_wdata=mb; rdy<=1 on the same edge; autoidx<=0 at exit of D3.
// ram_rd and ram_we are never high together; each is at most one clock per major cycle.
// State jump to H0 mid-cycle (halt) or reset: no write issued unless X3 already sampled; rdy<=0.
// Address arithmetic: 12-bit unsigned, wraps 7777->0000; no carry into field.
// TESTING
// Fetch: pc=0200, RAM[0200]=1234, F0..F3 -> ram_rd in F1 @0200, mb=1234 at F3, rdy=1 at F3, no ram_we.
// Auto-index: IR=1410 (TAD I 10), RAM[0010]=7777 -> D3 write 0000 to 0010, mb=0000, autoidx pulse D2-D3.
// Current-page defer: pc=4200, IR=1610 (TAD I, curr page, off 010) -> ea=4210, no auto-index, no write.
// DCA: IR=3050, exec_wr=1, exec_wdata=0077 -> E3 ram_we @0050 data 0077, mb=0077.
// Panel: sr=0300, trigger+panel_dep in H0 -> H3 writes RAM[0300]=0300; without dep -> read only, mb=RAM[0300].
// Reset asserted in D2 of auto-index cycle -> no ram_we, all outputs zero next clock.

Source files
------------

// File: rtl/mem_cycle_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_cycle_responder
// Description : Memory-side responder to the major-state sequencer. Each
//               four-phase major cycle (F/D/E/H, phases 0..3) runs one memory
//               cycle here: address the core RAM in X1, capture the word into
//               MB (optionally modified), and write MB back in X3 when the
//               cycle calls for it. Handles auto-index on deferred cycles to
//               0010-0017, E-cycle writes from the datapath, and panel
//               EXAM/DEP during H cycles. rdy tells the sequencer MB is valid.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           system clock
//   reset_i         synchronous active-high reset
//   state_i[4:0]    major state: [4]=0 for the sixteen cycle codes,
//                   [3:2] major (F=0, D=1, E=2, H=3), [1:0] phase (X0..X3)
//   instruction_i   current IR; PDP-8 bit k lives at vector bit 11-k
//   pc_i            program counter (same bit mapping)
//   exec_wr_i       datapath requests an E-cycle write (sampled in E2)
//   exec_wdata_i    data for the E-cycle write (sampled in E2)
//   sr_i            panel switch register
//   panel_dep_i     panel deposit request (sampled in H0 with trigger)
//   trigger_i       panel trigger
//   ram_addr_o      RAM address
//   ram_rd_o        RAM read strobe, one clock in X1
//   ram_we_o        RAM write strobe, one clock in X3 when a write is pending
//   ram_wdata_o     RAM write data (always MB)
//   ram_rdata_i     RAM read data, valid RD_LAT clocks after ram_rd_o
//   mb_o            memory buffer
//   ea_o            effective address of the current cycle
//   autoidx_o       high while an auto-index write-back is outstanding
//   rdy_o           MB valid for this cycle
// ============================================================================
module mem_cycle_responder #(
   parameter int AW     = 12,   // RAM address width, at most 12
   parameter int RD_LAT = 1     // RAM read latency in clocks, 1 or 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic [4:0]    state_i,
   input  logic [11:0]   instruction_i,
   input  logic [11:0]   pc_i,
   input  logic          exec_wr_i,
   input  logic [11:0]   exec_wdata_i,
   input  logic [11:0]   sr_i,
   input  logic          panel_dep_i,
   input  logic          trigger_i,
   output logic [AW-1:0] ram_addr_o,
   output logic          ram_rd_o,
   output logic          ram_we_o,
   output logic [11:0]   ram_wdata_o,
   input  logic [11:0]   ram_rdata_i,
   output logic [11:0]   mb_o,
   output logic [11:0]   ea_o,
   output logic          autoidx_o,
   output logic          rdy_o
);

   localparam logic [1:0] MAJ_F = 2'd0;
   localparam logic [1:0] MAJ_D = 2'd1;
   localparam logic [1:0] MAJ_E = 2'd2;
   localparam logic [1:0] MAJ_H = 2'd3;

   // The X1 clock itself is the address phase: it is served from IDLE so the
   // read strobe lines up with X1 without any look-ahead on state_i.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for X1; issues the read in X1
      ST_WAIT = 2'd1,   // extra read latency (RD_LAT = 2 only)
      ST_CAP  = 2'd2,   // read data valid: load MB
      ST_WB   = 2'd3    // write-back slot
   } fsm_t;

   fsm_t        fsm_q, fsm_d;
   logic [11:0] ea_q, ea_d;
   logic [11:0] mb_q, mb_d;
   logic [1:0]  major_q, major_d;
   logic        wpend_q, wpend_d;
   logic        rdy_q, rdy_d;
   logic        autoidx_q, autoidx_d;
   logic        dep_q, dep_d;
   logic        exwr_q, exwr_d;
   logic [11:0] exdata_q, exdata_d;

   logic        w_valid;
   logic [1:0]  w_major;
   logic [1:0]  w_phase;
   logic        w_x0, w_x1, w_x3, w_e2;
   logic [11:0] w_direct;
   logic [11:0] w_ea;
   logic        w_issue;
   logic        w_autoidx_hit;
   logic        w_exec_wr;
   logic [11:0] w_exec_wdata;
   logic        w_unused;

   assign w_valid = ~state_i[4];
   assign w_major = state_i[3:2];
   assign w_phase = state_i[1:0];
   assign w_x0    = w_valid && (w_phase == 2'd0);
   assign w_x1    = w_valid && (w_phase == 2'd1);
   assign w_x3    = w_valid && (w_phase == 2'd3);
   assign w_e2    = w_valid && (w_major == MAJ_E) && (w_phase == 2'd2);

   // Opcode bits only matter to the datapath.
   assign w_unused = ^instruction_i[11:9];

   // Direct address: IR bit 4 selects current page (PC bits 0:4) or page 0,
   // IR bits 5:11 give the offset within the page.
   assign w_direct = {instruction_i[7] ? pc_i[11:7] : 5'b0, instruction_i[6:0]};

   always_comb begin
      w_ea = pc_i;
      case (w_major)
         MAJ_F:   w_ea = pc_i;
         MAJ_D:   w_ea = w_direct;
         // Indirect E cycles use the pointer fetched by the preceding D cycle.
         MAJ_E:   w_ea = instruction_i[8] ? mb_q : w_direct;
         default: w_ea = sr_i;
      endcase
   end

   assign w_issue       = w_x1 && (fsm_q == ST_IDLE);
   // PDP-8 bits 0:8 of EA equal to octal 001 means address 0010-0017.
   assign w_autoidx_hit = (ea_q[11:3] == 9'o001);
   // With RD_LAT=1 capture coincides with E2, so take the live request then;
   // with RD_LAT=2 capture is in E3 and uses the copy latched during E2.
   assign w_exec_wr     = w_e2 ? exec_wr_i    : exwr_q;
   assign w_exec_wdata  = w_e2 ? exec_wdata_i : exdata_q;

   always_comb begin
      fsm_d     = fsm_q;
      ea_d      = ea_q;
      mb_d      = mb_q;
      major_d   = major_q;
      wpend_d   = wpend_q;
      rdy_d     = rdy_q;
      autoidx_d = autoidx_q;
      dep_d     = dep_q;
      exwr_d    = exwr_q;
      exdata_d  = exdata_q;
      ram_rd_o  = 1'b0;
      ram_we_o  = 1'b0;

      if (w_e2) begin
         exwr_d   = exec_wr_i;
         exdata_d = exec_wdata_i;
      end

      if (w_x0) begin
         // Start of a major cycle (or a halt jump to H0): abandon whatever
         // was in flight, including a write that X3 never reached.
         fsm_d     = ST_IDLE;
         wpend_d   = 1'b0;
         rdy_d     = 1'b0;
         autoidx_d = 1'b0;
         exwr_d    = 1'b0;
         if (w_major != MAJ_H) begin
            dep_d = 1'b0;
         end else if (trigger_i) begin
            dep_d = panel_dep_i;
         end
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (w_x1) begin
                  ram_rd_o = 1'b1;
                  ea_d     = w_ea;
                  major_d  = w_major;
                  fsm_d    = (RD_LAT == 2) ? ST_WAIT : ST_CAP;
               end
            end
            ST_WAIT: begin
               fsm_d = ST_CAP;
            end
            ST_CAP: begin
               rdy_d = 1'b1;
               fsm_d = ST_WB;
               mb_d  = ram_rdata_i;
               case (major_q)
                  MAJ_D: begin
                     if (w_autoidx_hit) begin
                        mb_d      = ram_rdata_i + 12'd1;
                        autoidx_d = 1'b1;
                        wpend_d   = 1'b1;
                     end
                  end
                  MAJ_E: begin
                     if (w_exec_wr) begin
                        mb_d    = w_exec_wdata;
                        wpend_d = 1'b1;
                     end
                  end
                  MAJ_H: begin
                     if (dep_q) begin
                        mb_d    = sr_i;
                        wpend_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            default: begin
               // Write only if the sequencer is really in X3; a jump away
               // before X3 drops the write.
               if (wpend_q && w_x3) begin
                  ram_we_o = 1'b1;
               end
               wpend_d   = 1'b0;
               autoidx_d = 1'b0;
               dep_d     = 1'b0;
               fsm_d     = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fsm_q     <= ST_IDLE;
         ea_q      <= 12'd0;
         mb_q      <= 12'd0;
         major_q   <= MAJ_F;
         wpend_q   <= 1'b0;
         rdy_q     <= 1'b0;
         autoidx_q <= 1'b0;
         dep_q     <= 1'b0;
         exwr_q    <= 1'b0;
         exdata_q  <= 12'd0;
      end else begin
         fsm_q     <= fsm_d;
         ea_q      <= ea_d;
         mb_q      <= mb_d;
         major_q   <= major_d;
         wpend_q   <= wpend_d;
         rdy_q     <= rdy_d;
         autoidx_q <= autoidx_d;
         dep_q     <= dep_d;
         exwr_q    <= exwr_d;
         exdata_q  <= exdata_d;
      end
   end

   assign ram_addr_o  = w_issue ? w_ea[AW-1:0] : ea_q[AW-1:0];
   assign ram_wdata_o = mb_q;
   assign mb_o        = mb_q;
   assign ea_o        = ea_q;
   assign autoidx_o   = autoidx_q;
   assign rdy_o       = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_cycle_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_cycle_responder
// Description : Self-checking bench for mem_cycle_responder. A RAM with one
//               clock read latency sits on the memory port; a word-level
//               reference model (shadow memory plus expected MB) predicts EA,
//               MB, write traffic and auto-index for each major cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_cycle_responder;

   localparam int AW = 12;
   localparam logic [1:0] F = 2'd0, D = 2'd1, E = 2'd2, H = 2'd3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [4:0]    state = 5'd0;
   logic [11:0]   instruction = 12'd0, pc = 12'd0, sr = 12'd0;
   logic          exec_wr = 1'b0, panel_dep = 1'b0, trigger = 1'b0;
   logic [11:0]   exec_wdata = 12'd0;
   logic [AW-1:0] ram_addr;
   logic          ram_rd, ram_we, autoidx, rdy;
   logic [11:0]   ram_wdata, ram_rdata, mb, ea;

   always #5 clk = ~clk;

   mem_cycle_responder #(.AW(AW), .RD_LAT(1)) dut (
      .clk_i(clk), .reset_i(reset), .state_i(state),
      .instruction_i(instruction), .pc_i(pc),
      .exec_wr_i(exec_wr), .exec_wdata_i(exec_wdata),
      .sr_i(sr), .panel_dep_i(panel_dep), .trigger_i(trigger),
      .ram_addr_o(ram_addr), .ram_rd_o(ram_rd), .ram_we_o(ram_we),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
      .mb_o(mb), .ea_o(ea), .autoidx_o(autoidx), .rdy_o(rdy)
   );

   // ---------------- RAM environment ----------------
   logic [11:0] ram [0:4095];
   logic [11:0] ref_mem [0:4095];
   logic        fill = 1'b1;
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = 12'd0, poke_data = 12'd0;

   function automatic logic [11:0] seed_word(int i);
      return 12'((i * 1061 + 345) % 4096);
   endfunction

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 4096; i++) ram[i] <= seed_word(i);
      end else if (poke_en) begin
         ram[poke_addr] <= poke_data;
      end else if (ram_we) begin
         ram[ram_addr] <= ram_wdata;
      end
      if (ram_rd) ram_rdata <= ram[ram_addr];
   end

   // ---------------- bus monitor ----------------
   int          rd_cnt = 0, we_cnt = 0, both_cnt = 0, ai_cnt = 0;
   logic [11:0] rd_addr_seen = 12'd0, we_addr_seen = 12'd0, we_data_seen = 12'd0;

   always @(negedge clk) begin
      if (ram_rd) begin rd_cnt++; rd_addr_seen = ram_addr; end
      if (ram_we) begin we_cnt++; we_addr_seen = ram_addr; we_data_seen = ram_wdata; end
      if (ram_rd && ram_we) both_cnt++;
      if (autoidx) ai_cnt++;
   end

   // ---------------- checking ----------------
   int          total = 0, bad = 0;
   logic [11:0] ref_mb = 12'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0o expected=%0o", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [11:0] d);
      poke_addr = a; poke_data = d; poke_en = 1'b1;
      tick();
      poke_en = 1'b0;
      ref_mem[a] = d;
   endtask

   // One full major cycle plus the model's prediction and the checks.
   task automatic run_cycle(input logic [1:0] maj, input logic [11:0] pc_v,
                            input logic [11:0] ir_v, input logic [11:0] sr_v,
                            input logic ewr, input logic [11:0] ewd,
                            input logic dep, input string tag);
      logic [11:0] direct, exp_ea, exp_mb;
      logic        exp_wr, exp_ai;
      int          rd0, we0, ai0, dwell, waited;

      direct = (((ir_v & 12'o0200) != 0) ? (pc_v & 12'o7600) : 12'o0000) | (ir_v & 12'o0177);
      exp_wr = 1'b0;
      exp_ai = 1'b0;
      case (maj)
         F: exp_ea = pc_v;
         D: exp_ea = direct;
         E: exp_ea = ((ir_v & 12'o0400) != 0) ? ref_mb : direct;
         default: exp_ea = sr_v;
      endcase
      exp_mb = ref_mem[exp_ea];
      if (maj == D && exp_ea >= 12'o0010 && exp_ea <= 12'o0017) begin
         exp_mb = 12'((int'(ref_mem[exp_ea]) + 1) % 4096);
         exp_wr = 1'b1;
         exp_ai = 1'b1;
      end else if (maj == E && ewr) begin
         exp_mb = ewd;
         exp_wr = 1'b1;
      end else if (maj == H && dep) begin
         exp_mb = sr_v;
         exp_wr = 1'b1;
      end

      rd0 = rd_cnt; we0 = we_cnt; ai0 = ai_cnt;
      pc = pc_v; instruction = ir_v; sr = sr_v;
      dwell = int'($urandom_range(1, 3));
      state = {1'b0, maj, 2'd0};
      for (int k = 0; k < dwell; k++) begin
         trigger   = (maj == H) && (k == dwell - 1);
         panel_dep = dep;
         tick();
      end
      trigger = 1'b0; panel_dep = 1'b0;
      check({tag, ".rdy_x0"}, 32'(rdy), 32'd0);
      state = {1'b0, maj, 2'd1};
      tick();
      state = {1'b0, maj, 2'd2};
      exec_wr = ewr; exec_wdata = ewd;
      tick();
      exec_wr = 1'b0;
      state = {1'b0, maj, 2'd3};
      waited = 0;
      while (!rdy && waited < 8) begin
         tick();
         waited++;
      end
      check({tag, ".rdy_x3"}, 32'(rdy), 32'd1);
      tick();

      if (exp_wr) ref_mem[exp_ea] = exp_mb;
      ref_mb = exp_mb;

      check({tag, ".ea"}, 32'(ea), 32'(exp_ea));
      check({tag, ".mb"}, 32'(mb), 32'(exp_mb));
      check({tag, ".rd_count"}, 32'(rd_cnt - rd0), 32'd1);
      check({tag, ".rd_addr"}, 32'(rd_addr_seen), 32'(exp_ea));
      check({tag, ".we_count"}, 32'(we_cnt - we0), 32'(exp_wr));
      if (exp_wr) begin
         check({tag, ".we_addr"}, 32'(we_addr_seen), 32'(exp_ea));
         check({tag, ".we_data"}, 32'(we_data_seen), 32'(exp_mb));
      end
      check({tag, ".autoidx"}, 32'(ai_cnt - ai0), 32'(exp_ai));
      check({tag, ".ram"}, 32'(ram[exp_ea]), 32'(ref_mem[exp_ea]));
   endtask

   initial begin
      int we0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);

      // ---- reset ----
      tick();
      fill = 1'b0;
      tick();
      reset = 1'b0;
      check("reset.ram_addr", 32'(ram_addr), 32'd0);
      check("reset.ram_rd", 32'(ram_rd), 32'd0);
      check("reset.ram_we", 32'(ram_we), 32'd0);
      check("reset.ram_wdata", 32'(ram_wdata), 32'd0);
      check("reset.mb", 32'(mb), 32'd0);
      check("reset.ea", 32'(ea), 32'd0);
      check("reset.autoidx", 32'(autoidx), 32'd0);
      check("reset.rdy", 32'(rdy), 32'd0);

      // ---- directed cycles ----
      poke(12'o0200, 12'o1234);
      run_cycle(F, 12'o0200, 12'o7000, 12'o0, 1'b0, 12'o0, 1'b0, "fetch");
      poke(12'o0010, 12'o7777);
      run_cycle(D, 12'o0201, 12'o1410, 12'o0, 1'b0, 12'o0, 1'b0, "autoidx");
      run_cycle(D, 12'o4200, 12'o1610, 12'o0, 1'b0, 12'o0, 1'b0, "curpage");
      run_cycle(E, 12'o0202, 12'o3050, 12'o0, 1'b1, 12'o0077, 1'b0, "dca");
      poke(12'o0300, 12'o5555);
      run_cycle(H, 12'o0203, 12'o0, 12'o0300, 1'b0, 12'o0, 1'b0, "exam");
      run_cycle(H, 12'o0203, 12'o0, 12'o0300, 1'b0, 12'o0, 1'b1, "dep");
      run_cycle(D, 12'o0204, 12'o1410, 12'o0, 1'b0, 12'o0, 1'b0, "autoidx2");
      run_cycle(E, 12'o0204, 12'o1410, 12'o0, 1'b0, 12'o0, 1'b0, "indirect");
      poke(12'o0017, 12'o7777);
      run_cycle(D, 12'o0205, 12'o1417, 12'o0, 1'b0, 12'o0, 1'b0, "ai_top");
      run_cycle(D, 12'o0205, 12'o1420, 12'o0, 1'b0, 12'o0, 1'b0, "ai_above");
      run_cycle(D, 12'o0205, 12'o1407, 12'o0, 1'b0, 12'o0, 1'b0, "ai_below");
      run_cycle(F, 12'o7777, 12'o0, 12'o0, 1'b0, 12'o0, 1'b0, "fetch_top");

      // ---- halt jump to H0 after E2: write must be dropped ----
      we0 = we_cnt;
      instruction = 12'o3050; pc = 12'o0210;
      state = {1'b0, E, 2'd0}; tick();
      state = {1'b0, E, 2'd1}; tick();
      state = {1'b0, E, 2'd2}; exec_wr = 1'b1; exec_wdata = 12'o0123; tick();
      exec_wr = 1'b0;
      state = {1'b0, H, 2'd0}; tick();
      tick();
      check("halt.we_count", 32'(we_cnt - we0), 32'd0);
      check("halt.rdy", 32'(rdy), 32'd0);
      check("halt.mb", 32'(mb), 32'o0123);
      check("halt.ram", 32'(ram[12'o0050]), 32'(ref_mem[12'o0050]));
      ref_mb = 12'o0123;

      // ---- reset in D2 of an auto-index cycle ----
      poke(12'o0010, 12'o7777);
      we0 = we_cnt;
      instruction = 12'o1410;
      state = {1'b0, D, 2'd0}; tick();
      state = {1'b0, D, 2'd1}; tick();
      state = {1'b0, D, 2'd2}; reset = 1'b1; tick();
      reset = 1'b0;
      check("rst_d2.ram_addr", 32'(ram_addr), 32'd0);
      check("rst_d2.ram_we", 32'(ram_we), 32'd0);
      check("rst_d2.ram_wdata", 32'(ram_wdata), 32'd0);
      check("rst_d2.mb", 32'(mb), 32'd0);
      check("rst_d2.ea", 32'(ea), 32'd0);
      check("rst_d2.autoidx", 32'(autoidx), 32'd0);
      check("rst_d2.rdy", 32'(rdy), 32'd0);
      state = {1'b0, D, 2'd3}; tick();
      check("rst_d2.we_count", 32'(we_cnt - we0), 32'd0);
      check("rst_d2.ram", 32'(ram[12'o0010]), 32'o7777);
      ref_mb = 12'd0;

      // ---- randomized major cycles ----
      for (int n = 0; n < 60; n++) begin
         logic [1:0]  m;
         logic [11:0] ir_r;
         m    = 2'($urandom_range(0, 3));
         ir_r = 12'($urandom);
         if ($urandom_range(0, 2) == 0) ir_r = 12'o1400 | 12'($urandom_range(8, 15));
         run_cycle(m, 12'($urandom), ir_r, 12'($urandom), 1'($urandom),
                   12'($urandom), 1'($urandom), "rand");
      end

      check("rd_we_overlap", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
